// File: rtl/gcd_scheduler.sv
// Round-robin arbiter sharing one GCD engine between two requesters.
// Latches operands on grant, starts the engine, and acks the owner with the result or a timeout.
module gcd_scheduler #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MAX_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy,
    output logic             owner,
    output logic             eng_start,
    output logic [WIDTH-1:0] eng_x,
    output logic [WIDTH-1:0] eng_y,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_result
);

    localparam int unsigned CW = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] LastCount = CW'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StAck
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] eng_x_q, eng_x_d;
    logic [WIDTH-1:0] eng_y_q, eng_y_d;
    logic [CW-1:0]    count_q, count_d;

    logic             grant;
    logic [WIDTH-1:0] grant_x;
    logic [WIDTH-1:0] grant_y;

    // Requester 1 wins when it is alone or when both ask and prio points at it.
    assign grant   = req1 && (!req0 || prio_q);
    assign grant_x = grant ? x1 : x0;
    assign grant_y = grant ? y1 : y0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            eng_x_q  <= '0;
            eng_y_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            err_q    <= err_d;
            result_q <= result_d;
            eng_x_q  <= eng_x_d;
            eng_y_q  <= eng_y_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        err_d    = err_q;
        result_d = result_q;
        eng_x_d  = eng_x_q;
        eng_y_d  = eng_y_q;
        count_d  = count_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    owner_d = grant;
                    eng_x_d = grant_x;
                    eng_y_d = grant_y;
                    if (grant_x == '0 || grant_y == '0) begin
                        // gcd(a, 0) == a, so no engine run is needed
                        result_d = grant_x | grant_y;
                        err_d    = 1'b0;
                        state_d  = StAck;
                    end else begin
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                count_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (eng_done) begin
                    result_d = eng_result;
                    err_d    = 1'b0;
                    state_d  = StAck;
                end else if (count_q == LastCount) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = StAck;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            StAck: begin
                prio_d  = !owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign eng_start = (state_q == StStart);
    assign ack0      = (state_q == StAck) && !owner_q;
    assign ack1      = (state_q == StAck) && owner_q;
    assign busy      = (state_q != StIdle);
    assign owner     = owner_q;
    assign result    = result_q;
    assign err       = err_q;
    assign eng_x     = eng_x_q;
    assign eng_y     = eng_y_q;

endmodule

// File: tb/tb_gcd_scheduler.sv
// Randomized bench for gcd_scheduler with a transaction-level reference model and a
// behavioural GCD engine that answers after a chosen number of WAIT cycles (or never).
module tb_gcd_scheduler;

    localparam int W    = 8;
    localparam int MAXC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] x0, y0, x1, y1;
    logic         ack0, ack1, err, busy, owner, eng_start;
    logic [W-1:0] result, eng_x, eng_y;
    logic         eng_done;
    logic [W-1:0] eng_result;

    gcd_scheduler #(.WIDTH(W), .MAX_CYCLES(MAXC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .req1       (req1),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .ack0       (ack0),
        .ack1       (ack1),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .owner      (owner),
        .eng_start  (eng_start),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic         prio_m = 1'b0;
    logic [W-1:0] last_res = '0;
    logic         pend0 = 1'b0, pend1 = 1'b0;
    logic [W-1:0] xs[2];
    logic [W-1:0] ys[2];

    // Engine model state
    int           eng_delay = 0;
    int           eng_k = 0;
    logic         eng_armed = 1'b0;
    logic         spur = 1'b0;
    logic [W-1:0] gcd_val;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] gcd(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
        int a = a_in;
        int b = b_in;
        while (b != 0) begin
            int t = a % b;
            a = b;
            b = t;
        end
        return W'(a);
    endfunction

    // Advance one cycle, then act as the engine for the cycle just entered.
    task automatic tick();
        @(posedge clk);
        #1;
        eng_done = 1'b0;
        if (eng_start) begin
            eng_armed = 1'b1;
            eng_k     = 0;
            gcd_val   = gcd(eng_x, eng_y);
            if (spur) begin
                eng_done   = 1'b1;
                eng_result = 8'hA5;
            end
        end else if (eng_armed) begin
            eng_k++;
            if (eng_k == eng_delay) begin
                eng_done   = 1'b1;
                eng_result = gcd_val;
                eng_armed  = 1'b0;
            end else if (eng_k >= MAXC + 1) begin
                eng_armed = 1'b0;
            end
        end
    endtask

    task automatic idle_spurious();
        eng_done   = 1'b1;
        eng_result = W'($urandom);
        tick();
        check("idle_spur_busy", busy, 1'b0);
        check("idle_spur_res", result, last_res);
    endtask

    // Called in an IDLE cycle; raises new requests, follows one grant through to its ack.
    task automatic run_txn(input logic n0, input logic n1,
                           input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1,
                           input int delay, input logic sp);
        logic         g, zero, tmo, seen;
        logic [W-1:0] gx, gy, exp_res;
        int           exp_lat, lat;
        if (n0 && !pend0) begin pend0 = 1'b1; xs[0] = a0; ys[0] = b0; end
        if (n1 && !pend1) begin pend1 = 1'b1; xs[1] = a1; ys[1] = b1; end
        if (!pend0 && !pend1) begin pend0 = 1'b1; xs[0] = a0; ys[0] = b0; end
        req0 = pend0; req1 = pend1;
        x0 = xs[0]; y0 = ys[0]; x1 = xs[1]; y1 = ys[1];
        g    = (pend0 && pend1) ? prio_m : pend1;
        gx   = xs[g];
        gy   = ys[g];
        zero = (gx == 0) || (gy == 0);
        tmo  = !zero && (delay < 1 || delay > MAXC);
        if (zero) begin
            exp_res = gx | gy; exp_lat = 1;
        end else if (tmo) begin
            exp_res = '0; exp_lat = MAXC + 2;
        end else begin
            exp_res = gcd(gx, gy); exp_lat = delay + 2;
        end
        eng_delay = zero ? 0 : delay;
        spur      = sp;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < MAXC + 6) begin
            tick();
            lat++;
            if (lat == 1) begin
                check("eng_start", eng_start, !zero);
                check("eng_x", eng_x, gx);
                check("eng_y", eng_y, gy);
            end
            if (ack0 || ack1) seen = 1'b1;
            else check("res_hold", result, last_res);
        end
        check("ack_seen", seen, 1'b1);
        if (seen) begin
            check("latency", lat, exp_lat);
            check("ack_vec", {ack1, ack0}, g ? 2'b10 : 2'b01);
            check("owner", owner, g);
            check("result", result, exp_res);
            check("err", err, tmo);
            check("busy_ack", busy, 1'b1);
        end
        if (g) pend1 = 1'b0;
        else pend0 = 1'b0;
        req0 = pend0; req1 = pend1;
        prio_m   = !g;
        last_res = exp_res;
        tick();
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int ack_cnt;
        rst = 1'b1;
        req0 = 0; req1 = 0; x0 = 0; y0 = 0; x1 = 0; y1 = 0;
        eng_done = 0; eng_result = 0;
        xs[0] = 0; ys[0] = 0; xs[1] = 0; ys[1] = 0;
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_acks", {ack1, ack0}, 2'b00);
        check("rst_start", eng_start, 1'b0);
        check("rst_owner", owner, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_result", result, 0);
        check("rst_eng_xy", {eng_x, eng_y}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_txn(1, 0, 8'd12, 8'd18, 8'd0, 8'd0, 3, 0);
        run_txn(0, 1, 8'd0, 8'd0, 8'd0, 8'd35, 2, 0);
        run_txn(1, 0, 8'd40, 8'd24, 8'd0, 8'd0, 0, 0);
        run_txn(0, 1, 8'd0, 8'd0, 8'd81, 8'd27, MAXC, 0);
        run_txn(1, 0, 8'd15, 8'd25, 8'd0, 8'd0, MAXC + 1, 1);
        idle_spurious();
        for (int i = 0; i < 4; i++)
            run_txn(1, 1, 8'd6 + 8'(i), 8'd9, 8'd14, 8'd21 + 8'(i), 1 + i % 3, 0);

        for (int i = 0; i < 250; i++) begin
            logic [W-1:0] a0, b0, a1, b1;
            a0 = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
            b0 = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
            a1 = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
            b1 = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
            if (!pend0 && !pend1 && $urandom_range(0, 5) == 0) idle_spurious();
            run_txn(1'($urandom), 1'($urandom), a0, b0, a1, b1,
                    $urandom_range(0, MAXC + 1), ($urandom_range(0, 3) == 0));
        end

        while (pend0 || pend1) run_txn(0, 0, 8'd0, 8'd0, 8'd0, 8'd0, 1, 0);
        run_txn(1, 0, 8'd8, 8'd12, 8'd0, 8'd0, 2, 0);

        // Abort a transaction in WAIT; prio must come back as 0.
        pend0 = 1'b1; req0 = 1'b1; x0 = 8'd9; y0 = 8'd6;
        eng_delay = 0; spur = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_acks", {ack1, ack0}, 2'b00);
        check("mid_rst_start", eng_start, 1'b0);
        check("mid_rst_out", {owner, err, result, eng_x, eng_y}, 0);
        req0 = 1'b0; pend0 = 1'b0; eng_armed = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            ack_cnt += int'(ack0 | ack1) + int'(busy);
        end
        check("post_rst_quiet", ack_cnt, 0);
        prio_m = 1'b0;
        last_res = '0;
        run_txn(1, 1, 8'd20, 8'd30, 8'd14, 8'd21, 2, 0);
        run_txn(0, 0, 8'd0, 8'd0, 8'd0, 8'd0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gcd_scheduler.md
# gcd_scheduler

Round-robin scheduler that shares one GCD engine (the ControlPath/datapath pair) between two requesters. It latches the granted requester's operand pair, starts the engine with a one-cycle pulse, and waits for the engine's done pulse or a timeout. It then returns the result to the owner with a one-cycle acknowledge. Zero-operand requests are answered directly without starting the engine.

## Interface
- WIDTH, 8: operand/result width.
- MAX_CYCLES, 255: WAIT-state cycles allowed before timeout (≥2).

- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- req0, req1  in  1  request levels; held high until the matching ack.
- x0, y0, x1, y1  in  WIDTH  operands; stable while the corresponding req is high.
- ack0, ack1  out  1  one-cycle result strobe to the owner.
- result  out  WIDTH  GCD result; valid in the ack cycle, held until the next ack.
- err  out  1  timeout flag; valid with ack.
- busy  out  1  high in every state except IDLE.
- owner  out  1  index of the current or last granted requester.
- eng_start  out  1  one-cycle engine start pulse.
- eng_x, eng_y  out  WIDTH  operands to the engine; held from grant until the next grant.
- eng_done  in  1  one-cycle engine completion pulse.
- eng_result  in  WIDTH  engine result; valid with eng_done.

## Operation
- States: IDLE, START, WAIT, ACK. Moore outputs: eng_start = (state==START); ackN = (state==ACK && owner==N); busy = (state!=IDLE).
- Internal priority bit prio, reset 0, meaning req0 is preferred.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester indicated by prio.
  - On grant: owner ← index; eng_x/eng_y ← that requester's x/y.
  - If either operand is 0: result ← x|y, err ← 0, go to ACK. The engine is never started.
  - Otherwise: go to START.
- START: eng_start = 1; cycle counter ← 0; go to WAIT.
- WAIT:
  - eng_done = 1: result ← eng_result, err ← 0, go to ACK.
  - Else if counter == MAX_CYCLES-1: result ← 0, err ← 1, go to ACK.
  - Otherwise: counter increments.
  - eng_done and timeout in the same cycle: done wins (err = 0).
- ACK: ack of owner = 1; prio ← ~owner; go to IDLE.
- eng_done outside WAIT is ignored. No state change, no result update.
- A requester drops req in the cycle after its ack. A req still high in IDLE is treated as a new request.
- req deasserted after grant: transaction completes anyway; ack is still issued.
- Counter width: $clog2(MAX_CYCLES)+1; no wrap is reachable.

## Timing
- Reset values (asynchronous): state IDLE; ack0, ack1, eng_start, err, busy, owner, prio = 0; result, eng_x, eng_y = 0; counter = 0.
- Reset mid-transaction: return to IDLE immediately. No ack is issued, no pending start is reissued, and prio returns to 0.
- Engine path: request seen in IDLE at cycle N; eng_start high in cycle N+1; eng_done at WAIT cycle M; ack in cycle M+1. Minimum latency request→ack is 3 cycles (done in the first WAIT cycle).
- Zero-operand path: request seen at cycle N; ack at cycle N+1.
- Timeout path: ack follows exactly MAX_CYCLES WAIT cycles, i.e. N+MAX_CYCLES+2.
- Back-to-back: the next grant can occur in the IDLE cycle right after ACK. Minimum period is 4 cycles per engine transaction.

## Test plan
- Single request, engine path: req0, x0=12, y0=18; bench engine pulses eng_done with 6 after 5 cycles → eng_start one cycle after req; eng_x=12, eng_y=18; ack0 one cycle after done; result=6, err=0; ack1 stays 0.
- Contention and fairness: req0 and req1 high together and held (re-raised after each ack) → grants alternate 0,1,0,1; prio toggles after each ack; owner matches each ack.
- Zero operand: req1, x1=0, y1=35 → ack1 exactly 1 cycle after IDLE sample; result=35; eng_start never pulses.
- Timeout: MAX_CYCLES=4, engine never responds → ack at start+5; result=0, err=1. Separately, eng_done on the timeout cycle → err=0 and result=eng_result.
- Spurious done: eng_done pulsed in IDLE and in START → no state change, result unchanged.
- Reset mid-WAIT: assert rst asynchronously during WAIT → busy=0 and all outputs 0 immediately; no ack after release. Next request with both reqs high grants req0.
